// File: rtl/imem_loader_if.sv
// imem_loader_if: bundles the program byte stream and the instruction-memory
// write bus of the program loader.
//   in_valid/in_data/in_last : byte stream from the image source
//   in_ready                 : loader accepts a byte this cycle
//   imem_we/addr/wdata       : one-cycle instruction-memory word write
// Modports: slave = loader side, master = stream source / memory side.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit instruction
// words, writes them to instruction memory at byte addresses 0,4,8,... and
// holds the CPU in reset until the image has been loaded.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : one-cycle pulse starting a load (ignored while loading)
//   bus        : imem_loader_if.slave (byte stream in, memory write out)
//   cpu_reset  : active-high CPU reset, low only when the load is done
//   done       : image loaded successfully
//   err        : load aborted (partial final word or memory overflow)
//   word_count : words written since the last start
//   checksum   : (only with IMEM_LOADER_CHECKSUM_EN) sum mod 2^32 of the
//                written words, valid while done is high
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int IMEM_WORDS = 64,
    parameter int CNT_W      = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    imem_loader_if.slave     bus,
    output logic             cpu_reset,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_byte_idx;
    logic [23:0]      r_lanes;      // byte lanes 0..2 of the word in progress
    logic             r_last_seen;
    logic [CNT_W-1:0] r_word_count;
    logic [63:0]      r_addr;
    logic [31:0]      r_wdata;

    logic w_hs;
    logic w_start_ok;
    logic w_full;
    logic w_word_done;

    assign w_hs        = (r_state == S_LOAD) && bus.in_valid;
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERROR));
    assign w_full      = (r_word_count == CNT_W'(IMEM_WORDS));
    assign w_word_done = w_hs && (r_byte_idx == 2'd3) && !w_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_hs) begin
                    if (r_byte_idx == 2'd3) begin
                        w_next = w_full ? S_ERROR : S_WRITE;
                    end else if (bus.in_last) begin
                        w_next = S_ERROR;
                    end
                end
            end
            S_WRITE: begin
                w_next = r_last_seen ? S_DONE : S_LOAD;
            end
            S_DONE, S_ERROR: begin
                if (start) w_next = S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Address and data are captured on the byte-3 handshake so they are
    // stable during WRITE and keep their values afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_idx   <= '0;
            r_lanes      <= '0;
            r_last_seen  <= 1'b0;
            r_word_count <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_start_ok) begin
            r_byte_idx   <= '0;
            r_word_count <= '0;
            r_last_seen  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0:    r_lanes[7:0]   <= bus.in_data;
                    2'd1:    r_lanes[15:8]  <= bus.in_data;
                    2'd2:    r_lanes[23:16] <= bus.in_data;
                    default: ;
                endcase
            end
            if (w_word_done) begin
                r_addr      <= 64'({r_word_count, 2'b00});
                r_wdata     <= {bus.in_data, r_lanes};
                r_last_seen <= bus.in_last;
            end
            if (r_state == S_WRITE) begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (r_state == S_WRITE) begin
            r_checksum <= r_checksum + r_wdata;
        end
    end

    assign checksum = r_checksum;
`endif

    assign bus.in_ready   = (r_state == S_LOAD);
    assign bus.imem_we    = (r_state == S_WRITE);
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign cpu_reset      = (r_state != S_DONE);
    assign done           = (r_state == S_DONE);
    assign err            = (r_state == S_ERROR);
    assign word_count     = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed, table-driven bench for imem_loader.
// dut_a uses the default 64-word memory; dut_b uses a 4-word memory for the
// overflow case.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a, start_b;

    imem_loader_if bus_a ();
    imem_loader_if bus_b ();

    logic       cpu_reset_a, done_a, err_a;
    logic [6:0] wc_a;
    logic       cpu_reset_b, done_b, err_b;
    logic [2:0] wc_b;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_a, checksum_b;
`endif

    imem_loader #(.IMEM_WORDS(64), .CNT_W(7)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start_a),
        .bus        (bus_a),
        .cpu_reset  (cpu_reset_a),
        .done       (done_a),
        .err        (err_a),
        .word_count (wc_a)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum_a)
`endif
    );

    imem_loader #(.IMEM_WORDS(4), .CNT_W(3)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start_b),
        .bus        (bus_b),
        .cpu_reset  (cpu_reset_b),
        .done       (done_b),
        .err        (err_b),
        .word_count (wc_b)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum_b)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Write monitors, sampled on the falling edge.
    int          cyc = 0;
    logic [63:0] wa_addr[$];
    logic [31:0] wa_data[$];
    int          wa_cyc[$];
    int          wb_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_a.imem_we === 1'b1) begin
            wa_addr.push_back(bus_a.imem_addr);
            wa_data.push_back(bus_a.imem_wdata);
            wa_cyc.push_back(cyc);
        end
        if (bus_b.imem_we === 1'b1) wb_count = wb_count + 1;
    end

    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        rdy;
        logic        we;
        logic [63:0] addr;
        logic [31:0] wd;
        logic        dn;
        logic        er;
        logic        cr;
        logic [6:0]  wc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic v, logic [7:0] d, logic l,
                                logic rdy, logic we, logic [63:0] addr,
                                logic [31:0] wd, logic dn, logic er, logic cr,
                                logic [6:0] wc);
        vec_t r;
        r.st = st; r.v = v; r.d = d; r.l = l;
        r.rdy = rdy; r.we = we; r.addr = addr; r.wd = wd;
        r.dn = dn; r.er = er; r.cr = cr; r.wc = wc;
        return r;
    endfunction

    function automatic logic [107:0] pk(logic rdy, logic we, logic [63:0] addr,
                                        logic [31:0] wd, logic dn, logic er,
                                        logic cr, logic [6:0] wc);
        return {rdy, we, addr, wd, dn, er, cr, wc};
    endfunction

    function automatic logic [107:0] obs_a();
        return pk(bus_a.in_ready, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata,
                  done_a, err_a, cpu_reset_a, wc_a);
    endfunction

    function automatic logic [107:0] obs_b();
        return pk(bus_b.in_ready, bus_b.imem_we, bus_b.imem_addr, bus_b.imem_wdata,
                  done_b, err_b, cpu_reset_b, {4'b0, wc_b});
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(int sel, logic v, logic [7:0] d, logic l);
        if (sel == 0) begin
            bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_last = l;
        end else begin
            bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_last = l;
        end
    endtask

    // Presents one byte and waits (bounded) until it has been accepted.
    // Returns at posedge+1 of the cycle after the handshake edge.
    task automatic send_byte(int sel, logic [7:0] d, logic l);
        logic hs;
        logic ok;
        set_in(sel, 1'b1, d, l);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            hs = (sel == 0) ? bus_a.in_ready : bus_b.in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL hs_timeout: dut %0d byte %0h not accepted within 20 cycles", sel, d);
        end
    endtask

    task automatic pulse_start(int sel);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    logic [31:0] exp_w;

    initial begin
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 128'(obs_a()), 128'(pk(0, 0, 64'h0, 32'h0, 0, 0, 1, 7'd0)));
        check("reset_b", 128'(obs_b()), 128'(pk(0, 0, 64'h0, 32'h0, 0, 0, 1, 7'd0)));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_a", 128'(obs_a()), 128'(pk(0, 0, 64'h0, 32'h0, 0, 0, 1, 7'd0)));

        // ---- single word, valid gaps, start ignored in WRITE/LOAD, partial word error
        //            st v  d      l  rdy we addr    wdata           dn er cr wc
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 64'd0, 32'h0,        0, 0, 1, 7'd0));
        vecs.push_back(mk(0, 1, 8'h93, 0, 1, 0, 64'd0, 32'h0,        0, 0, 1, 7'd0));
        vecs.push_back(mk(0, 0, 8'hAB, 0, 1, 0, 64'd0, 32'h0,        0, 0, 1, 7'd0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 64'd0, 32'h0,        0, 0, 1, 7'd0));
        vecs.push_back(mk(0, 1, 8'h50, 0, 1, 0, 64'd0, 32'h0,        0, 0, 1, 7'd0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 1, 64'd0, 32'h00500093, 0, 0, 1, 7'd0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 64'd0, 32'h00500093, 1, 0, 0, 7'd1));
        vecs.push_back(mk(0, 1, 8'hFF, 1, 0, 0, 64'd0, 32'h00500093, 1, 0, 0, 7'd1));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 64'd0, 32'h00500093, 0, 0, 1, 7'd0));
        vecs.push_back(mk(0, 1, 8'hDD, 0, 1, 0, 64'd0, 32'h00500093, 0, 0, 1, 7'd0));
        vecs.push_back(mk(0, 1, 8'hCC, 0, 1, 0, 64'd0, 32'h00500093, 0, 0, 1, 7'd0));
        vecs.push_back(mk(0, 1, 8'hBB, 0, 1, 0, 64'd0, 32'h00500093, 0, 0, 1, 7'd0));
        vecs.push_back(mk(0, 1, 8'hAA, 0, 0, 1, 64'd0, 32'hAABBCCDD, 0, 0, 1, 7'd0));
        vecs.push_back(mk(1, 1, 8'h11, 0, 1, 0, 64'd0, 32'hAABBCCDD, 0, 0, 1, 7'd1));
        vecs.push_back(mk(1, 1, 8'h11, 0, 1, 0, 64'd0, 32'hAABBCCDD, 0, 0, 1, 7'd1));
        vecs.push_back(mk(0, 1, 8'h22, 0, 1, 0, 64'd0, 32'hAABBCCDD, 0, 0, 1, 7'd1));
        vecs.push_back(mk(0, 1, 8'h33, 0, 1, 0, 64'd0, 32'hAABBCCDD, 0, 0, 1, 7'd1));
        vecs.push_back(mk(0, 1, 8'h44, 0, 0, 1, 64'd4, 32'h44332211, 0, 0, 1, 7'd1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 64'd4, 32'h44332211, 0, 0, 1, 7'd2));
        vecs.push_back(mk(0, 1, 8'h55, 0, 1, 0, 64'd4, 32'h44332211, 0, 0, 1, 7'd2));
        vecs.push_back(mk(0, 1, 8'h66, 0, 1, 0, 64'd4, 32'h44332211, 0, 0, 1, 7'd2));
        vecs.push_back(mk(0, 1, 8'h77, 1, 0, 0, 64'd4, 32'h44332211, 0, 1, 1, 7'd2));
        vecs.push_back(mk(0, 1, 8'h88, 0, 0, 0, 64'd4, 32'h44332211, 0, 1, 1, 7'd2));
        vecs.push_back(mk(1, 0, 8'h00, 0, 1, 0, 64'd4, 32'h44332211, 0, 0, 1, 7'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            start_a = vecs[i].st;
            set_in(0, vecs[i].v, vecs[i].d, vecs[i].l);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 128'(obs_a()),
                  128'(pk(vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wd,
                          vecs[i].dn, vecs[i].er, vecs[i].cr, vecs[i].wc)));
        end
        start_a = 1'b0;
        set_in(0, 1'b0, 8'h00, 1'b0);

        // ---- asynchronous reset during byte 2 of word 1, then clean restart
        send_byte(0, 8'h01, 1'b0);
        send_byte(0, 8'h02, 1'b0);
        send_byte(0, 8'h03, 1'b0);
        send_byte(0, 8'h04, 1'b0);
        send_byte(0, 8'h05, 1'b0);
        send_byte(0, 8'h06, 1'b0);
        set_in(0, 1'b1, 8'h07, 1'b0);
        #3;
        check("preabort_wc", 128'(wc_a), 128'(7'd1));
        reset = 1'b0;
        #1;
        check("async_reset", 128'(obs_a()), 128'(pk(0, 0, 64'h0, 32'h0, 0, 0, 1, 7'd0)));
        set_in(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
        pulse_start(0);
        send_byte(0, 8'h13, 1'b0);
        send_byte(0, 8'h05, 1'b0);
        send_byte(0, 8'h10, 1'b0);
        send_byte(0, 8'h00, 1'b1);
        set_in(0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("restart_nwr", 128'(wa_addr.size()), 128'(1));
        if (wa_addr.size() == 1) begin
            check("restart_addr", 128'(wa_addr[0]), 128'(64'd0));
            check("restart_data", 128'(wa_data[0]), 128'(32'h00100513));
        end
        check("restart_done", 128'({done_a, cpu_reset_a, wc_a}), 128'({1'b1, 1'b0, 7'd1}));

        // ---- 15 words at full rate
        wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
        pulse_start(0);
        for (int w = 0; w < 15; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(0, 8'(w * 4 + b), (w == 14) && (b == 3));
            end
        end
        set_in(0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("full_done", 128'({done_a, cpu_reset_a, err_a, wc_a}),
              128'({1'b1, 1'b0, 1'b0, 7'd15}));
        check("full_nwr", 128'(wa_addr.size()), 128'(15));
        if (wa_addr.size() == 15) begin
            for (int w = 0; w < 15; w++) begin
                exp_w = {8'(w * 4 + 3), 8'(w * 4 + 2), 8'(w * 4 + 1), 8'(w * 4)};
                check($sformatf("full_addr%0d", w), 128'(wa_addr[w]), 128'(64'(w * 4)));
                check($sformatf("full_data%0d", w), 128'(wa_data[w]), 128'(exp_w));
                if (w > 0) begin
                    check($sformatf("full_gap%0d", w), 128'(wa_cyc[w] - wa_cyc[w-1]), 128'(5));
                end
            end
        end

        // ---- overflow on a 4-word memory
        pulse_start(1);
        for (int w = 0; w < 5; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(1, 8'(8'hA0 + w * 4 + b), 1'b0);
            end
        end
        set_in(1, 1'b0, 8'h00, 1'b0);
        check("ovf_state", 128'({err_b, cpu_reset_b, done_b, bus_b.imem_we, bus_b.in_ready, wc_b}),
              128'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4}));
        check("ovf_last_addr", 128'(bus_b.imem_addr), 128'(64'd12));
        @(posedge clk);
        #1;
        check("ovf_nwr", 128'(wb_count), 128'(4));
        check("ovf_hold", 128'(err_b), 128'(1'b1));

`ifdef IMEM_LOADER_CHECKSUM_EN
        // ---- checksum wraps to zero for 0x00000001 + 0xFFFFFFFF
        pulse_start(0);
        send_byte(0, 8'h01, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'hFF, 1'b0);
        send_byte(0, 8'hFF, 1'b0);
        check("cks_mid", 128'(checksum_a), 128'(32'h1));
        send_byte(0, 8'hFF, 1'b0);
        send_byte(0, 8'hFF, 1'b1);
        set_in(0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("cks_done", 128'({done_a, checksum_a}), 128'({1'b1, 32'h0}));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
